// File: rtl/axi_mmio_pkg.sv
// Shared constants, status layout and write-FSM states for the MMIO sink.
package axi_mmio_pkg;

    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [31:0] DEF_STATUS_ADDR  = 32'h1000_0004;
    localparam logic [31:0] DEF_PASS_ADDR    = 32'h2000_0000;
    localparam logic [31:0] DEF_PASS_MAGIC   = 32'd123456789;
    localparam logic [31:0] DEAD_BEEF        = 32'hDEAD_BEEF;

    localparam int unsigned STAT_EMPTY     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        StIdle,
        StHaveAw,
        StHaveW,
        StExec,
        StResp
    } wr_state_e;

    function automatic logic [31:0] status_word(input logic [7:0] cnt, input logic full,
                                                input logic empty);
        logic [31:0] w;
        w = '0;
        w[STAT_COUNT_LSB +: 8] = cnt;
        w[STAT_FULL]           = full;
        w[STAT_EMPTY]          = empty;
        return w;
    endfunction

endpackage

// File: rtl/axi_mmio_sink_if.sv
// AXI4-lite style bus without response codes: valid/ready/data per channel.
interface axi_mmio_sink_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );

endinterface

// File: rtl/mmio_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO succeeds only with a pop.
module mmio_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/axi_mmio_sink.sv
// Console/test-result MMIO slave feeding a TX byte FIFO.
// Define AXI_MMIO_SINK_STALL_EN to gate readies and pushes with a free-running LFSR.
module axi_mmio_sink
    import axi_mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
    parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR,
    parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC
) (
    input  logic                 clk,
    input  logic                 resetn,
    axi_mmio_sink_if.slave       bus,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 tests_passed,
    output logic                 bad_access
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_e   state;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
    logic        strb0_q;

    logic [3:0]    gate;
    logic          aw_hit, w_hit, ar_hit;
    logic          have_aw, have_w;
    logic          want_push, exec_done, waddr_bad, raddr_bad;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   rd_word;
    logic          unused_strb;

    assign unused_strb = ^bus.wstrb[3:1];

`ifdef AXI_MMIO_SINK_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign gate = lfsr[3:0];
`else
    assign gate = 4'hF;
`endif

    assign bus.awready = awready_q && gate[0];
    assign bus.wready  = wready_q && gate[1];
    assign bus.arready = arready_q && gate[2];
    assign bus.bvalid  = bvalid_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;

    always_comb begin
        aw_hit    = bus.awvalid && bus.awready;
        w_hit     = bus.wvalid && bus.wready;
        ar_hit    = bus.arvalid && bus.arready;
        have_aw   = (state == StHaveAw) || aw_hit;
        have_w    = (state == StHaveW) || w_hit;
        waddr_bad = (waddr_q != CONSOLE_ADDR) && (waddr_q != STATUS_ADDR) &&
                    (waddr_q != PASS_ADDR);
        raddr_bad = (bus.araddr != STATUS_ADDR) && (bus.araddr != PASS_ADDR);
        want_push = (state == StExec) && (waddr_q == CONSOLE_ADDR) && strb0_q;
        fifo_pop  = tx_valid && tx_ready;
        // Full FIFO only accepts when the head leaves in the same cycle.
        fifo_push = want_push && (!fifo_full || fifo_pop) && gate[3];
        exec_done = (state == StExec) && (!want_push || fifo_push);
        if (bus.araddr == STATUS_ADDR) begin
            rd_word = status_word(8'(fifo_count), fifo_full, fifo_empty);
        end else if (bus.araddr == PASS_ADDR) begin
            rd_word = {31'b0, tests_passed};
        end else begin
            rd_word = DEAD_BEEF;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= StIdle;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            tests_passed <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            strb0_q      <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StHaveAw, StHaveW: begin
                    if (aw_hit) waddr_q <= bus.awaddr;
                    if (w_hit) begin
                        wdata_q <= bus.wdata;
                        strb0_q <= bus.wstrb[0];
                    end
                    if (have_aw && have_w) begin
                        state     <= StExec;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else if (have_aw) begin
                        state     <= StHaveAw;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                    end else if (have_w) begin
                        state     <= StHaveW;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b0;
                    end else begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                StExec: begin
                    if (exec_done) begin
                        if (waddr_q == PASS_ADDR && wdata_q == PASS_MAGIC) tests_passed <= 1'b1;
                        state    <= StResp;
                        bvalid_q <= 1'b1;
                    end
                end
                StResp: begin
                    if (bus.bready) begin
                        state     <= StIdle;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else if (rvalid_q) begin
            if (bus.rready) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
            end
        end else if (ar_hit) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_word;
        end else begin
            arready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bad_access <= 1'b0;
        end else if ((state == StExec && waddr_bad) || (ar_hit && raddr_bad)) begin
            bad_access <= 1'b1;
        end
    end

    mmio_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .din    (wdata_q[7:0]),
        .pop    (fifo_pop),
        .dout   (tx_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign tx_valid = !fifo_empty;

endmodule

// File: tb/tb_axi_mmio_sink.sv
// Scoreboard bench for axi_mmio_sink: expected read data and TX bytes are queued at issue time.
module tb_axi_mmio_sink;

    localparam logic [31:0] CONSOLE = 32'h1000_0000;
    localparam logic [31:0] STATUS  = 32'h1000_0004;
    localparam logic [31:0] PASS    = 32'h2000_0000;
    localparam logic [31:0] MAGIC   = 32'd123456789;

    logic       clk = 1'b0;
    logic       resetn;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tests_passed;
    logic       bad_access;

    int checks = 0;
    int errors = 0;

    logic [31:0] rq[$];
    logic [7:0]  txq[$];

    axi_mmio_sink_if bus ();

    axi_mmio_sink dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tests_passed (tests_passed),
        .bad_access   (bad_access)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (resetn && bus.rvalid && bus.rready) begin
                if (rq.size() == 0) begin
                    fail("r_unexpected");
                end else begin
                    e = rq.pop_front();
                    check("rdata", bus.rdata, e);
                end
            end
            if (resetn && tx_valid && tx_ready) begin
                if (txq.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL tx_unexpected: got byte %h, expected none", tx_data);
                end else begin
                    e = {24'b0, txq.pop_front()};
                    check("tx_data", {24'b0, tx_data}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b(input int max, output bit got);
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.bvalid && bus.bready) got = 1'b1;
            step();
            if (got) break;
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lag, input bit queue_tx,
                             input bit want_b);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit got;
        int cyc = 0;
        if (queue_tx && addr == CONSOLE && strb[0]) txq.push_back(data[7:0]);
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 100) begin
            bus.awvalid = !aw_done;
            bus.wvalid  = !w_done && (cyc >= w_lag);
            @(negedge clk);
            if (bus.awvalid && bus.awready) aw_done = 1'b1;
            if (bus.wvalid && bus.wready) w_done = 1'b1;
            step();
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) fail("aw_w_accept");
        if (want_b) begin
            wait_b(20, got);
            check("bresp", {31'b0, got}, 32'd1);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input int hold);
        bit done = 1'b0;
        bit seen = 1'b0;
        rq.push_back(exp);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        if (hold > 0) bus.rready = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.arready) done = 1'b1;
            step();
        end
        bus.arvalid = 1'b0;
        if (!done) begin
            fail("ar_accept");
            void'(rq.pop_back());
            bus.rready = 1'b1;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rvalid_hold", {31'b0, bus.rvalid}, 32'd1);
            check("rdata_hold", bus.rdata, exp);
            step();
        end
        bus.rready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rvalid;
            step();
        end
        if (!seen) fail("rvalid");
    endtask

    task automatic drain(input int max);
        tx_ready = 1'b1;
        for (int i = 0; i < max && txq.size() != 0; i++) step();
        check("tx_drained", txq.size(), 32'd0);
        step();
        check("tx_valid_idle", {31'b0, tx_valid}, 32'd0);
    endtask

    initial begin
        bit got;
        int nb;
        bit done;
        resetn      = 1'b0;
        tx_ready    = 1'b0;
        bus.awvalid = 1'b0;
        bus.awaddr  = '0;
        bus.wvalid  = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.bready  = 1'b1;
        bus.arvalid = 1'b0;
        bus.araddr  = '0;
        bus.rready  = 1'b1;
        step();
        step();
        check("rst_awready", {31'b0, bus.awready}, 32'd0);
        check("rst_wready", {31'b0, bus.wready}, 32'd0);
        check("rst_arready", {31'b0, bus.arready}, 32'd0);
        check("rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
        check("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_passed", {31'b0, tests_passed}, 32'd0);
        check("rst_bad", {31'b0, bad_access}, 32'd0);
        resetn = 1'b1;
        step();
        step();

        // Single console byte, W two cycles after AW.
        tx_ready = 1'b1;
        axi_write(CONSOLE, 32'h41, 4'hF, 2, 1'b1, 1'b1);
        drain(10);

        // strobe bit 0 clear: no byte.
        axi_write(CONSOLE, 32'h99, 4'hE, 0, 1'b1, 1'b1);
        drain(5);

        // Fill the FIFO, then a 17th write must stall until a pop.
        tx_ready = 1'b0;
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            axi_write(CONSOLE, 32'h50 + i, 4'h1, i % 3, 1'b1, 1'b0);
            wait_b(20, got);
            if (got) nb++;
        end
        check("fill_bresp_count", nb, 32'd16);
        axi_read(STATUS, 32'h0000_1002, 0);
        axi_write(CONSOLE, 32'h60, 4'h1, 0, 1'b1, 1'b0);
        wait_b(10, got);
        check("full_stall_no_b", {31'b0, got}, 32'd0);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        wait_b(8, got);
        check("full_after_pop_b", {31'b0, got}, 32'd1);
        drain(40);

        // Pass flag is sticky.
        axi_write(PASS, MAGIC, 4'hF, 0, 1'b0, 1'b1);
        check("passed_set", {31'b0, tests_passed}, 32'd1);
        axi_write(PASS, 32'd0, 4'hF, 1, 1'b0, 1'b1);
        check("passed_sticky", {31'b0, tests_passed}, 32'd1);
        axi_read(PASS, 32'd1, 0);

        // Status with three queued bytes, rready held off.
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) axi_write(CONSOLE, 32'h61 + i, 4'h1, 0, 1'b1, 1'b1);
        axi_read(STATUS, 32'h0000_0300, 3);
        drain(20);
        axi_read(STATUS, 32'h0000_0001, 0);

        // Unmapped read.
        check("bad_before", {31'b0, bad_access}, 32'd0);
        axi_read(32'h0000_0010, 32'hDEAD_BEEF, 0);
        check("bad_after_read", {31'b0, bad_access}, 32'd1);

        // Reset with AW latched and five bytes queued.
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) axi_write(CONSOLE, 32'h70 + i, 4'h1, 0, 1'b0, 1'b1);
        bus.awaddr  = PASS;
        bus.awvalid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.awready) done = 1'b1;
            step();
        end
        bus.awvalid = 1'b0;
        if (!done) fail("aw_only_accept");
        resetn = 1'b0;
        step();
        check("mid_rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
        check("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("mid_rst_passed", {31'b0, tests_passed}, 32'd0);
        check("mid_rst_bad", {31'b0, bad_access}, 32'd0);
        resetn = 1'b1;
        step();
        axi_read(STATUS, 32'h0000_0001, 0);
        tx_ready = 1'b1;
        axi_write(CONSOLE, 32'h77, 4'h1, 1, 1'b1, 1'b1);
        drain(10);
        check("fresh_bad", {31'b0, bad_access}, 32'd0);

        // Unmapped write still completes.
        axi_write(32'h3000_0000, 32'h1234, 4'hF, 0, 1'b0, 1'b1);
        check("bad_after_write", {31'b0, bad_access}, 32'd1);

        repeat (5) step();
        check("rq_empty", rq.size(), 32'd0);
        check("txq_empty", txq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_mmio_sink.md
Name: axi_mmio_sink

Overview:
- AXI4-lite slave for the simulation/FPGA top. It sits beside the main memory slave on the picorv32_axi bus, downstream of the address decoder.
- Owns the console and test-result MMIO registers: console byte writes go into a TX FIFO drained by a valid/ready byte stream (UART or host printer); writes of the pass magic set a sticky tests_passed flag.
- No bresp/rresp channels: the bus carries valid/ready/data only, like picorv32_axi.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries (power of two, >=2)
- CONSOLE_ADDR, 32'h1000_0000, write: push wdata[7:0]
- STATUS_ADDR, 32'h1000_0004, read: FIFO status
- PASS_ADDR, 32'h2000_0000, write: magic check; read: {31'b0, tests_passed}
- PASS_MAGIC, 32'd123456789, value that sets tests_passed

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  32  write address
- wvalid/wready  in/out  1  write data handshake
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- bvalid/bready  out/in  1  write response handshake
- arvalid/arready  in/out  1  read address handshake
- araddr  in  32  read address
- rvalid/rready  out/in  1  read data handshake
- rdata  out  32  read data
- tx_valid/tx_ready  out/in  1  console byte stream handshake
- tx_data  out  8  FIFO head byte
- tests_passed  out  1  sticky pass flag
- bad_access  out  1  sticky: unmapped address touched

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. Reset drives all readies, bvalid, rvalid, tx_valid, tests_passed and bad_access to 0, rdata to 0, FIFO empty. Reset mid-transaction discards latched AW/W/AR and FIFO contents.
- Write path states: IDLE, HAVE_AW, HAVE_W, EXEC, RESP.
  - AW and W are accepted independently, in any order or in the same cycle.
  - awready is high iff no address is latched and bvalid=0; wready likewise for data. The handshake is valid&&ready at posedge.
  - EXEC is entered the cycle after both are latched.
  - CONSOLE_ADDR with wstrb[0]=1: push wdata[7:0]. If the FIFO is full with no pop that cycle, stay in EXEC (backpressure, never drop). A push into a full FIFO is allowed when a pop happens in the same cycle.
  - CONSOLE_ADDR with wstrb[0]=0: no push.
  - PASS_ADDR: wdata==PASS_MAGIC sets tests_passed (sticky until reset); other values are ignored.
  - STATUS_ADDR write: ignored.
  - Any other address: bad_access<=1.
  - RESP: bvalid=1 until bready, then return to IDLE. At most one write is outstanding.
- Read path:
  - arready=1 iff no read is latched and rvalid=0.
  - On accept, rvalid rises the next cycle with rdata:
    - STATUS_ADDR: {16'b0, count[7:0], 6'b0, full, empty}
    - PASS_ADDR: {31'b0, tests_passed}
    - other: 32'hDEAD_BEEF, and bad_access<=1
  - rdata stays stable while rvalid && !rready.
  - Reads and writes proceed concurrently.
- FIFO:
  - tx_valid = !empty; tx_data = head; pop on tx_valid&&tx_ready.
  - count is width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - A pushed byte is visible on tx_data no earlier than the next cycle (1-cycle latency).
- Address compare uses all 32 bits, exact match; unaligned addresses count as unmapped.

Optional Feature:
- AXI_MMIO_SINK_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, advances every cycle) gates the readies. awready, wready, arready and the EXEC push are each masked by LFSR bits [0],[1],[2],[3] respectively. This stresses master handshakes.
- Undefined: no LFSR, no gating; timing exactly as above.

Decomposition:
- Package axi_mmio_pkg: default address constants, PASS_MAGIC, STATUS bit indices (EMPTY=0, FULL=1, COUNT lsb=8), DEAD_BEEF constant, write-FSM state enum.
- Sub-module mmio_sync_fifo (DEPTH, WIDTH=8; push/pop/full/empty/count).

Test Plan:
- AW then W two cycles later to CONSOLE_ADDR, wdata=0x41, tx_ready=1 -> one bvalid pulse; tx_valid with tx_data=0x41 for one cycle.
- tx_ready=0, 17 console writes with FIFO_DEPTH=16 -> 16 bvalids; the 17th stalls with no bvalid until one tx pop, then completes; bytes emerge in order.
- Write 123456789 to PASS_ADDR -> tests_passed=1; then write 0 -> tests_passed stays 1; read PASS_ADDR -> rdata=1.
- 3 bytes queued, tx_ready=0, read STATUS_ADDR -> rdata=0x0000_0300; rready held low 3 cycles -> rdata stable.
- Write to 0x3000_0000 and read 0x0000_0010 -> bvalid still completes; rdata=0xDEADBEEF; bad_access=1.
- resetn low for 1 cycle with AW latched and 5 bytes queued -> bvalid=0, tx_valid=0, count=0; the next write behaves as fresh.
